// File: rtl/cmd_responder.sv
// cmd_responder: answers the host four-phase cmd handshake, range-checks the command and launches one pipeline op.
// Latency: cmd_valid seen at edge E -> cmd_ack/start/busy high after E+2; cmd_ack drops on the edge cmd_valid is seen low.
// Backpressure: requests are sampled only in IDLE; a request raised during an operation waits unacknowledged until it ends.
module cmd_responder #(
    parameter int ANGLE_MAX = 90,
    parameter int TIMEOUT   = 1048575
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cmd,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    input  logic       done,
    output logic       cmd_ack,
    output logic       busy,
    output logic       start,
    output logic [3:0] op,
    output logic [7:0] op_arg,
    output logic       error,
    output logic [1:0] err_code
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_ACK    = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    localparam logic [3:0]  OP_ROTATE    = 4'd0;
    localparam logic [3:0]  OP_GRAYSCALE = 4'd1;
    localparam logic [3:0]  OP_RM_GREEN  = 4'd2;
    localparam logic [3:0]  OP_CLEAR     = 4'd3;

    localparam logic [1:0]  ERR_OPCODE   = 2'd1;
    localparam logic [1:0]  ERR_RANGE    = 2'd2;
    localparam logic [1:0]  ERR_TIMEOUT  = 2'd3;

    // Watchdog terminal value; the fault fires on the busy edge that sees this count.
    localparam logic [19:0] LP_WD_LAST   = 20'(TIMEOUT - 1);
    localparam logic [31:0] LP_ANGLE_MAX = ANGLE_MAX;

    state_t      r_state;

    // Flopped copy of the host bus; IDLE works from these so decode never sees a raw async-ish input.
    logic        r_vld_q;
    logic [3:0]  r_cmd_q;
    logic [7:0]  r_data_q;

    // Command latched on the IDLE->DECODE transition.
    logic [3:0]  r_cmd;
    logic [7:0]  r_data;

    logic [19:0] r_wdog;

    logic        w_arg_ok;
    logic        w_launch;
    logic        w_done_take;
    logic        w_wd_expire;
    logic        w_busy_end;

    // Register the host request bus once before the FSM looks at it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_q  <= 1'b0;
            r_cmd_q  <= '0;
            r_data_q <= '0;
        end else begin
            r_vld_q  <= cmd_valid;
            r_cmd_q  <= cmd;
            r_data_q <= cmd_data;
        end
    end

    assign w_arg_ok    = ({24'd0, r_data} <= LP_ANGLE_MAX);
    assign w_launch    = ((r_cmd == OP_ROTATE) && w_arg_ok) ||
                         (r_cmd == OP_GRAYSCALE) ||
                         (r_cmd == OP_RM_GREEN);
    // done only matters while an operation is in flight; done wins over a coincident expiry.
    assign w_done_take = busy && done;
    assign w_wd_expire = busy && !done && (r_wdog == LP_WD_LAST);
    assign w_busy_end  = w_done_take || w_wd_expire;

    // Command FSM with registered outputs, watchdog and sticky fault reporting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cmd    <= '0;
            r_data   <= '0;
            r_wdog   <= '0;
            cmd_ack  <= 1'b0;
            busy     <= 1'b0;
            start    <= 1'b0;
            op       <= '0;
            op_arg   <= '0;
            error    <= 1'b0;
            err_code <= '0;
        end else begin
            start <= 1'b0;

            if (busy) begin
                r_wdog <= r_wdog + 20'd1;
            end

            if (w_done_take) begin
                busy <= 1'b0;
            end else if (w_wd_expire) begin
                busy     <= 1'b0;
                error    <= 1'b1;
                err_code <= ERR_TIMEOUT;
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_vld_q) begin
                        r_cmd   <= r_cmd_q;
                        r_data  <= r_data_q;
                        r_state <= ST_DECODE;
                    end
                end

                ST_DECODE: begin
                    cmd_ack <= 1'b1;
                    r_state <= ST_ACK;
                    if (w_launch) begin
                        op     <= r_cmd;
                        op_arg <= r_data;
                        start  <= 1'b1;
                        busy   <= 1'b1;
                        r_wdog <= '0;
                    end else if (r_cmd == OP_CLEAR) begin
                        error    <= 1'b0;
                        err_code <= '0;
                    end else begin
                        error    <= 1'b1;
                        err_code <= (r_cmd == OP_ROTATE) ? ERR_RANGE : ERR_OPCODE;
                    end
                end

                ST_ACK: begin
                    // Host must drop its request before we move on; an op that already ended skips RUN.
                    if (!cmd_valid) begin
                        cmd_ack <= 1'b0;
                        r_state <= (busy && !w_busy_end) ? ST_RUN : ST_IDLE;
                    end
                end

                ST_RUN: begin
                    if (w_busy_end) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_responder.sv
// Directed bench for cmd_responder: instance A uses default parameters, instance B uses TIMEOUT=16.
// Each instance is held in reset while the other is exercised; both share the host-side inputs.
module tb_cmd_responder;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1;
    logic       rst_b = 1'b1;
    logic [3:0] cmd = '0;
    logic [7:0] cmd_data = '0;
    logic       cmd_valid = 1'b0;
    logic       done = 1'b0;

    logic       a_cmd_ack, a_busy, a_start, a_error;
    logic [3:0] a_op;
    logic [7:0] a_op_arg;
    logic [1:0] a_err_code;

    logic       b_cmd_ack, b_busy, b_start, b_error;
    logic [3:0] b_op;
    logic [7:0] b_op_arg;
    logic [1:0] b_err_code;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cmd_responder dut_a (
        .clk(clk), .rst(rst_a), .cmd(cmd), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .done(done),
        .cmd_ack(a_cmd_ack), .busy(a_busy), .start(a_start), .op(a_op), .op_arg(a_op_arg),
        .error(a_error), .err_code(a_err_code)
    );

    cmd_responder #(.ANGLE_MAX(90), .TIMEOUT(16)) dut_b (
        .clk(clk), .rst(rst_b), .cmd(cmd), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .done(done),
        .cmd_ack(b_cmd_ack), .busy(b_busy), .start(b_start), .op(b_op), .op_arg(b_op_arg),
        .error(b_error), .err_code(b_err_code)
    );

    // Advance one rising edge and settle just after it.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raise a request and advance to the edge on which ack/start are expected (E+2).
    task automatic launch(input logic [3:0] c, input logic [7:0] d);
        cmd       = c;
        cmd_data  = d;
        cmd_valid = 1'b1;
        step(3);
    endtask

    // Drop the request and advance over the edge that samples it low.
    task automatic release_req();
        cmd_valid = 1'b0;
        step(1);
    endtask

    task automatic pulse_done();
        done = 1'b1;
        step(1);
        done = 1'b0;
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        step(2);
        n_tests++; if ({a_cmd_ack, a_busy, a_start, a_op, a_op_arg, a_error, a_err_code} !== 18'd0) begin n_fail++; $display("FAIL reset_outs: got %h want 0", {a_cmd_ack, a_busy, a_start, a_op, a_op_arg, a_error, a_err_code}); end
        rst_a = 1'b0;
        step(1);
        launch(4'd1, 8'd0);
        release_req();
        n_tests++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL reset_prerun_busy: got %b want 1", a_busy); end
        rst_a = 1'b1;
        step(2);
        n_tests++; if ({a_cmd_ack, a_busy, a_start, a_op, a_op_arg, a_error, a_err_code} !== 18'd0) begin n_fail++; $display("FAIL reset_midrun: got %h want 0", {a_cmd_ack, a_busy, a_start, a_op, a_op_arg, a_error, a_err_code}); end
        rst_a = 1'b0;
        step(1);
        launch(4'd2, 8'd0);
        n_tests++; if ({a_cmd_ack, a_start, a_busy, a_op} !== {3'b111, 4'd2}) begin n_fail++; $display("FAIL reset_next_cmd: got %b want 1110010", {a_cmd_ack, a_start, a_busy, a_op}); end
        release_req();
        pulse_done();
        n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_next_done: got %b want 0", a_busy); end
    endtask

    task automatic test_rotate();
        cmd       = 4'd0;
        cmd_data  = 8'd30;
        cmd_valid = 1'b1;
        step(2);                                   // E, E+1
        n_tests++; if (a_start !== 1'b0 || a_cmd_ack !== 1'b0) begin n_fail++; $display("FAIL rot_early: start=%b ack=%b want 0 0", a_start, a_cmd_ack); end
        step(1);                                   // E+2
        n_tests++; if ({a_start, a_cmd_ack, a_busy} !== 3'b111) begin n_fail++; $display("FAIL rot_launch: got %b want 111", {a_start, a_cmd_ack, a_busy}); end
        n_tests++; if (a_op !== 4'd0 || a_op_arg !== 8'd30) begin n_fail++; $display("FAIL rot_op: op=%0d arg=%0d want 0 30", a_op, a_op_arg); end
        step(1);                                   // E+3
        n_tests++; if (a_start !== 1'b0 || a_cmd_ack !== 1'b1) begin n_fail++; $display("FAIL rot_start_1cyc: start=%b ack=%b want 0 1", a_start, a_cmd_ack); end
        step(1);                                   // E+4, valid held 5 edges
        n_tests++; if (a_cmd_ack !== 1'b1) begin n_fail++; $display("FAIL rot_ack_hold: got %b want 1", a_cmd_ack); end
        release_req();                             // E+5
        n_tests++; if (a_cmd_ack !== 1'b0 || a_busy !== 1'b1) begin n_fail++; $display("FAIL rot_ack_fall: ack=%b busy=%b want 0 1", a_cmd_ack, a_busy); end
        step(16);                                  // E+21
        n_tests++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL rot_busy_hold: got %b want 1", a_busy); end
        pulse_done();                              // done sampled at E+22, 20 cycles after start
        n_tests++; if (a_busy !== 1'b0 || a_error !== 1'b0) begin n_fail++; $display("FAIL rot_done: busy=%b err=%b want 0 0", a_busy, a_error); end
    endtask

    task automatic test_faults();
        launch(4'd0, 8'd91);
        n_tests++; if ({a_cmd_ack, a_start, a_busy, a_error, a_err_code} !== 6'b100110) begin n_fail++; $display("FAIL flt_range: got %b want 100110", {a_cmd_ack, a_start, a_busy, a_error, a_err_code}); end
        release_req();
        n_tests++; if (a_cmd_ack !== 1'b0) begin n_fail++; $display("FAIL flt_range_ack: got %b want 0", a_cmd_ack); end
        launch(4'd9, 8'd0);
        n_tests++; if ({a_cmd_ack, a_start, a_error, a_err_code} !== 5'b10101) begin n_fail++; $display("FAIL flt_opcode: got %b want 10101", {a_cmd_ack, a_start, a_error, a_err_code}); end
        release_req();
        // Boundary angle is legal and launches even with the sticky error set.
        launch(4'd0, 8'd90);
        n_tests++; if ({a_start, a_op_arg, a_error, a_err_code} !== {1'b1, 8'd90, 1'b1, 2'd1}) begin n_fail++; $display("FAIL flt_angle_max: got %h want %h", {a_start, a_op_arg, a_error, a_err_code}, {1'b1, 8'd90, 1'b1, 2'd1}); end
        release_req();
        pulse_done();
        launch(4'd3, 8'd0);
        n_tests++; if ({a_cmd_ack, a_start, a_busy, a_error, a_err_code} !== 6'b100000) begin n_fail++; $display("FAIL flt_clear: got %b want 100000", {a_cmd_ack, a_start, a_busy, a_error, a_err_code}); end
        release_req();
    endtask

    task automatic test_timeout();
        rst_a = 1'b1;
        rst_b = 1'b0;
        step(1);
        n_tests++; if ({b_cmd_ack, b_busy, b_start, b_error, b_err_code} !== 6'd0) begin n_fail++; $display("FAIL to_reset: got %b want 0", {b_cmd_ack, b_busy, b_start, b_error, b_err_code}); end
        launch(4'd1, 8'd0);                        // start at S
        n_tests++; if (b_start !== 1'b1) begin n_fail++; $display("FAIL to_start: got %b want 1", b_start); end
        release_req();                             // S+1
        step(14);                                  // S+15
        n_tests++; if (b_busy !== 1'b1 || b_error !== 1'b0) begin n_fail++; $display("FAIL to_before: busy=%b err=%b want 1 0", b_busy, b_error); end
        step(1);                                   // S+16
        n_tests++; if ({b_busy, b_error, b_err_code} !== 4'b0111) begin n_fail++; $display("FAIL to_expire: got %b want 0111", {b_busy, b_error, b_err_code}); end
        pulse_done();
        n_tests++; if ({b_busy, b_error, b_err_code} !== 4'b0111) begin n_fail++; $display("FAIL to_late_done: got %b want 0111", {b_busy, b_error, b_err_code}); end
    endtask

    task automatic test_race_expiry();
        launch(4'd3, 8'd0);
        release_req();
        n_tests++; if (b_error !== 1'b0) begin n_fail++; $display("FAIL race_clear: got %b want 0", b_error); end
        launch(4'd1, 8'd0);                        // S
        release_req();                             // S+1
        step(14);                                  // S+15
        pulse_done();                              // done sampled at S+16, the expiry edge
        n_tests++; if ({b_busy, b_error, b_err_code} !== 4'b0000) begin n_fail++; $display("FAIL race_expiry: got %b want 0000", {b_busy, b_error, b_err_code}); end
    endtask

    task automatic test_done_in_ack();
        launch(4'd2, 8'd7);
        n_tests++; if ({b_busy, b_cmd_ack} !== 2'b11) begin n_fail++; $display("FAIL ack_done_pre: got %b want 11", {b_busy, b_cmd_ack}); end
        pulse_done();
        n_tests++; if ({b_busy, b_cmd_ack} !== 2'b01) begin n_fail++; $display("FAIL ack_done_busy: got %b want 01", {b_busy, b_cmd_ack}); end
        step(1);
        n_tests++; if (b_cmd_ack !== 1'b1) begin n_fail++; $display("FAIL ack_done_hold: got %b want 1", b_cmd_ack); end
        release_req();
        n_tests++; if ({b_busy, b_cmd_ack, b_error} !== 3'b000) begin n_fail++; $display("FAIL ack_done_exit: got %b want 000", {b_busy, b_cmd_ack, b_error}); end
        // FSM must be back in IDLE: a new command follows the normal E+2 timing.
        launch(4'd1, 8'd3);
        n_tests++; if ({b_start, b_cmd_ack, b_busy, b_op} !== {3'b111, 4'd1}) begin n_fail++; $display("FAIL ack_done_next: got %b want 1110001", {b_start, b_cmd_ack, b_busy, b_op}); end
        release_req();
        pulse_done();
    endtask

    task automatic test_queued();
        launch(4'd1, 8'd0);                        // S
        release_req();                             // S+1, RUN
        cmd       = 4'd2;
        cmd_data  = 8'd4;
        cmd_valid = 1'b1;
        step(3);                                   // S+4
        n_tests++; if ({b_cmd_ack, b_start, b_busy} !== 3'b001) begin n_fail++; $display("FAIL q_pending: got %b want 001", {b_cmd_ack, b_start, b_busy}); end
        pulse_done();                              // D
        n_tests++; if ({b_cmd_ack, b_busy} !== 2'b00) begin n_fail++; $display("FAIL q_done: got %b want 00", {b_cmd_ack, b_busy}); end
        step(1);                                   // D+1
        n_tests++; if (b_cmd_ack !== 1'b0) begin n_fail++; $display("FAIL q_ack_early: got %b want 0", b_cmd_ack); end
        step(1);                                   // D+2
        n_tests++; if ({b_cmd_ack, b_start, b_busy, b_op, b_op_arg} !== {3'b111, 4'd2, 8'd4}) begin n_fail++; $display("FAIL q_launch: got %h want %h", {b_cmd_ack, b_start, b_busy, b_op, b_op_arg}, {3'b111, 4'd2, 8'd4}); end
        release_req();
        pulse_done();
        n_tests++; if ({b_busy, b_error} !== 2'b00) begin n_fail++; $display("FAIL q_finish: got %b want 00", {b_busy, b_error}); end
    endtask

    initial begin
        test_reset();
        test_rotate();
        test_faults();
        test_timeout();
        test_race_expiry();
        test_done_in_ack();
        test_queued();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: bench did not finish, got running want finished");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/cmd_responder.md
# cmd_responder

Command-interface responder for the image-processing top level. It answers the host's `cmd`/`cmd_data`/`cmd_valid` four-phase handshake with `cmd_ack`, decodes and range-checks each command, and launches one pipeline operation with a single-cycle `start` pulse. It then holds `busy` until the pipeline reports `done` or a watchdog expires, and reports faults on a sticky `error` flag with an `err_code`.

## Interface
Parameters:
- `ANGLE_MAX`, default 90: largest legal rotate angle, in degrees, for `cmd_data`.
- `TIMEOUT`, default 1048575: number of busy cycles allowed without `done` before a timeout fault. Must be ≥ 2 and < 2^20.

Ports (clock and reset first):
- `clk`  in  1  the single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd`  in  4  command opcode from the host.
- `cmd_data`  in  8  command argument from the host.
- `cmd_valid`  in  1  host request; `cmd`/`cmd_data` are stable while it is high.
- `done`  in  1  single-cycle completion pulse from the pipeline.
- `cmd_ack`  out  1  acknowledge to the host.
- `busy`  out  1  an operation is in flight.
- `start`  out  1  one-cycle launch pulse to the pipeline.
- `op`  out  4  latched opcode of the launched operation.
- `op_arg`  out  8  latched argument of the launched operation.
- `error`  out  1  sticky fault flag.
- `err_code`  out  2  last fault: 1 = illegal opcode, 2 = argument out of range, 3 = timeout.

## Operation
- All outputs are registered. On `rst`, every output is 0, the FSM goes to IDLE, and the watchdog counter is cleared. Reset mid-operation abandons the operation; no `start` or `cmd_ack` is emitted on the reset cycle.
- Opcodes:
  - 0: ROTATE. Legal when `cmd_data` ≤ `ANGLE_MAX`; otherwise fault code 2.
  - 1: GRAYSCALE. `cmd_data` is ignored.
  - 2: REMOVE_GREEN. `cmd_data` is ignored.
  - 3: CLEAR. Clears `error` and `err_code`; launches nothing.
  - 4–15: illegal, fault code 1.
- FSM states:
  - IDLE: when `cmd_valid` = 1, latch `cmd`/`cmd_data` and go to DECODE.
  - DECODE: one cycle.
    - Legal op (0–2): `op` and `op_arg` take the latched values; set `start` = 1, `busy` = 1, `cmd_ack` = 1; clear the watchdog. Go to ACK.
    - CLEAR: clear the error state; set `cmd_ack` = 1. Go to ACK.
    - Fault: set `error` = 1 and `err_code` to the fault code; set `cmd_ack` = 1; `start` stays 0. Go to ACK.
  - ACK: `start` returns to 0 after one cycle. `cmd_ack` holds until `cmd_valid` is sampled 0. On that edge `cmd_ack` goes to 0 and the next state is RUN if `busy` = 1, otherwise IDLE.
  - RUN: wait for `done` or a watchdog expiry. Either event clears `busy` and returns the FSM to IDLE.
- `done` is accepted in ACK or RUN while `busy` = 1. If it arrives in ACK, `busy` drops immediately and ACK exits to IDLE. `done` while `busy` = 0 is ignored.
- Watchdog:
  - 20-bit counter that increments every cycle while `busy` = 1.
  - When it reaches `TIMEOUT`-1 and `done` is not asserted that cycle: `error` = 1, `err_code` = 3, `busy` = 0.
  - If `done` and expiry coincide, `done` wins and no fault is raised.
- `cmd_valid` is sampled only in IDLE. A request made while RUN is pending stays unacknowledged until IDLE.
- `error` is sticky and only CLEAR or `rst` clears it. A new fault overwrites `err_code`. Legal ops still launch while `error` = 1.

## Timing
- `cmd_valid` seen in IDLE at edge E: `cmd_ack`, `start` and `busy` are 1 after edge E+2. `start` is 0 after E+3.
- `cmd_valid` sampled 0 at edge F while in ACK: `cmd_ack` is 0 after F.
- `done` sampled at edge D: `busy` is 0 after D.
- Timeout: `busy` is 0 and `error` is 1 after the edge on which the counter reaches `TIMEOUT`-1. That is `TIMEOUT` busy cycles after `start`.
- Minimum back-to-back command spacing is 4 cycles. The `cmd_valid` low phase must last at least 1 cycle.

## Test plan
- Reset: hold `rst` 2 cycles mid-RUN → all outputs 0 and state IDLE; the next command is accepted normally.
- Rotate: `cmd`=0, `cmd_data`=30, `cmd_valid` held 5 cycles, `done` 20 cycles after `start` → `start` high exactly 1 cycle, `op`=0, `op_arg`=30, `cmd_ack` falls 1 edge after `cmd_valid` falls, `busy` high until `done`, `error`=0.
- Faults:
  - `cmd`=0, `cmd_data`=91 → `cmd_ack` asserted, no `start`, `error`=1, `err_code`=2.
  - Then `cmd`=9 → `err_code`=1.
  - Then `cmd`=3 → `error`=0, `err_code`=0.
- Timeout: `TIMEOUT`=16, `cmd`=1, never pulse `done` → `busy` drops 16 cycles after `start`, `err_code`=3. A `done` pulsed afterwards is ignored.
- Race: `done` on the exact expiry cycle → no error. `done` during ACK (with `cmd_valid` still high) → `busy` drops, FSM returns to IDLE after `cmd_valid` falls.
- Queued request: assert a second `cmd_valid` during RUN → no `cmd_ack` until after `done`; it is then acknowledged and launched.
